sram_ctrl: RTL and testbench
============================

# sram_ctrl

Initiator side of the bcrypt S-box SRAM word interface. Accepts single-word read/write requests from the bcrypt core over a valid/ready handshake and drives the SRAM word-line address, read/write select and bit lines. Runs a four-phase handshake against the SRAM's `data_ready`/`op_type` and returns one response per request. Includes an access timeout and an operation-type check.

## Interface
- `ADDR_W`, 8: word-line address width.
- `DATA_W`, 64: bit-line/data width.
- `TIMEOUT`, 15: max cycles in ACCESS or RELEASE before error; range 1..255.

- `clk` in 1: clock, all flops on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `req_write` in 1: 1 write, 0 read.
- `req_addr` in ADDR_W: word address.
- `req_wdata` in DATA_W: write data.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed when `rsp_valid && rsp_ready`.
- `rsp_write` out 1: echo of the request's `req_write`.
- `rsp_rdata` out DATA_W: read data; 0 for writes and errors.
- `rsp_err` out 1: timeout or op_type mismatch.
- `sram_wl` out ADDR_W: word-line address.
- `sram_rw_sel` out 1: 0 read, 1 write.
- `sram_bl` out DATA_W: bit lines; all ones = read precharge, `req_wdata` = write.
- `sram_data_ready` in 1: SRAM completion, level.
- `sram_op_type` in 1: SRAM's registered copy of `rw_sel`.
- `sram_rdata` in DATA_W: read data, valid while `sram_data_ready`=1.

## Operation
- All outputs are registered.
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_write`=0, `rsp_rdata`=0, `rsp_err`=0, `sram_wl`=0, `sram_rw_sel`=0, `sram_bl`=0.
- The SRAM idle drive is wl=0, rw_sel=0, bl=0. All-ones bl is never idle, because it would hold `data_ready` high.
- FSM states: IDLE, ACCESS, RESP, RELEASE. Reset state is IDLE.
- IDLE:
  - `req_ready`=1 unless `sram_data_ready`=1.
  - On accept: latch addr, write flag and wdata, clear the timer, go to ACCESS.
- ACCESS:
  - Drive `sram_wl`=addr and `sram_rw_sel`=write.
  - Drive `sram_bl` = wdata for writes, all ones for reads.
  - Timer increments each cycle.
  - On `sram_data_ready`=1:
    - capture `rsp_rdata` = read ? `sram_rdata` : 0;
    - `rsp_err` = (`sram_op_type` != write);
    - go to RESP.
  - If the timer reaches TIMEOUT first: `rsp_err`=1, `rsp_rdata`=0, go to RESP.
  - If `data_ready` and timeout occur in the same cycle, `data_ready` wins.
- RESP:
  - Drive idle on the SRAM; `rsp_valid`=1.
  - Response fields are stable until the handshake completes.
  - On `rsp_ready`: `rsp_valid` drops next cycle; clear the timer; go to RELEASE.
- RELEASE:
  - Keep the idle drive and wait for `sram_data_ready`=0, then go to IDLE.
  - Timeout here returns to IDLE anyway. This error is not reported, because the response was already delivered.
- Timer width is clog2(TIMEOUT+1) and it saturates; it never wraps.
- Reset asserted mid-operation: every output takes its reset value immediately, with no response emitted. A partially issued access is abandoned.

## Timing
- Request accepted on edge of cycle 0.
- SRAM drive is visible in cycle 1.
- Against a standard SRAM (`data_ready` 2 cycles after drive), `data_ready` is seen in cycle 3.
- `rsp_valid` rises in cycle 4.
- With `rsp_ready` tied high:
  - idle drive in cycle 4, `data_ready` low in cycle 6;
  - RELEASE→IDLE at end of cycle 6, `req_ready`=1 in cycle 7.
- Best-case throughput: one operation per 7 cycles.
- `req_ready` is never high while `rsp_valid` is high.
- `sram_*` outputs never change during ACCESS.

## Test plan
- Read addr 0x2A with the SRAM returning 0xDEADBEEF_01234567 → in ACCESS, `sram_bl`=all ones and `rw_sel`=0. `rsp_valid` in cycle 4 with that data, `rsp_err`=0, `rsp_write`=0.
- Write addr 0x05, data 0x0123456789ABCDEF → `sram_bl` equals that data and `rw_sel`=1. Response has `rsp_rdata`=0 and `rsp_err`=0. `req_ready` returns in cycle 7.
- SRAM `data_ready` stuck low, TIMEOUT=15 → `rsp_valid` with `rsp_err`=1 and `rsp_rdata`=0 exactly 15 cycles after entering ACCESS.
- `sram_op_type`=1 returned on a read → `rsp_err`=1.
- Hold `rsp_ready` low for 10 cycles → all rsp fields stable, `req_ready`=0 throughout, and `sram_data_ready` falls during RESP. Then `req_ready`=1 one cycle after RELEASE is entered.
- Assert `rst` in cycle 2 of a write → `sram_rw_sel`=0, `sram_bl`=0 and `rsp_valid`=0 immediately. After release, the next request completes normally.

Source files
------------

// File: rtl/sram_ctrl.sv
// Initiator for the bcrypt S-box SRAM word port: one request in, one four-phase
// SRAM access, one response out, with access timeout and op_type checking.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | SRAM idle-driven; req_ready high while data_ready is low
// ACCESS  | wl/rw_sel/bl driven, waiting for data_ready or timeout
// RESP    | SRAM idle-driven, response held until rsp_ready
// RELEASE | waiting for data_ready to fall (bounded by timeout)
module sram_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] sram_wl,
  output logic              sram_rw_sel,
  output logic [DATA_W-1:0] sram_bl,
  input  logic              sram_data_ready,
  input  logic              sram_op_type,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LIM = TMR_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESP    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t           state;
  logic [TMR_W-1:0] tmr;
  logic [TMR_W-1:0] tmr_next;
  logic             tmr_done;
  logic             wr_q;
  logic             op_bad;

  // Saturating timer: once at the limit it stays there.
  assign tmr_next = (tmr == TMR_LIM) ? tmr : tmr + TMR_W'(1);
  assign tmr_done = (tmr_next == TMR_LIM);
  assign op_bad   = (sram_op_type != wr_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      tmr         <= '0;
      wr_q        <= 1'b0;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      sram_wl     <= '0;
      sram_rw_sel <= 1'b0;
      sram_bl     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            wr_q        <= req_write;
            tmr         <= '0;
            req_ready   <= 1'b0;
            sram_wl     <= req_addr;
            sram_rw_sel <= req_write;
            // Reads precharge the bit lines high; writes drive the data.
            sram_bl     <= req_write ? req_wdata : '1;
            state       <= ACCESS;
          end else begin
            req_ready <= !sram_data_ready;
          end
        end

        ACCESS: begin
          tmr <= tmr_next;
          if (sram_data_ready || tmr_done) begin
            // data_ready has priority over a coincident timeout.
            if (sram_data_ready) begin
              rsp_err   <= op_bad;
              rsp_rdata <= (!wr_q && !op_bad) ? sram_rdata : '0;
            end else begin
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end
            rsp_write   <= wr_q;
            rsp_valid   <= 1'b1;
            sram_wl     <= '0;
            sram_rw_sel <= 1'b0;
            sram_bl     <= '0;
            state       <= RESP;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            tmr       <= '0;
            state     <= RELEASE;
          end
        end

        RELEASE: begin
          tmr <= tmr_next;
          // A stuck data_ready here is dropped silently; the response is gone.
          if (!sram_data_ready || tmr_done) begin
            req_ready <= !sram_data_ready;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Randomized bench for sram_ctrl: a behavioural SRAM with a reference memory,
// cycle-accurate response timing expectations and directed corner cases.
module tb_sram_ctrl;
  localparam int AW = 8;
  localparam int DW = 64;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] sram_wl;
  logic          sram_rw_sel;
  logic [DW-1:0] sram_bl;
  logic          sram_data_ready;
  logic          sram_op_type;
  logic [DW-1:0] sram_rdata;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit overlap = 1'b0;

  sram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .sram_wl(sram_wl), .sram_rw_sel(sram_rw_sel), .sram_bl(sram_bl),
    .sram_data_ready(sram_data_ready), .sram_op_type(sram_op_type),
    .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (req_ready && rsp_valid) overlap <= 1'b1;

  function automatic logic [DW-1:0] seed(input logic [AW-1:0] a);
    if (a == 8'h2A) return 64'hDEADBEEF_01234567;
    return {24'hA5C3E1, a, 24'h5A3C1E, ~a};
  endfunction

  // Behavioural SRAM: completion two cycles after it sees a drive, drops two
  // cycles after the drive returns to idle; writes commit on first sight.
  logic [DW-1:0] sram_mem [256];
  bit            sram_wr  [256];
  logic          stage1 = 1'b0;
  logic          dr_q = 1'b0;
  logic          op_q = 1'b0;
  logic [DW-1:0] rd_q = '0;
  bit            stuck = 1'b0;
  bit            flip = 1'b0;

  always @(posedge clk) begin
    stage1 <= sram_rw_sel || (&sram_bl);
    dr_q   <= stage1;
    op_q   <= sram_rw_sel ^ flip;
    if (sram_rw_sel) begin
      sram_mem[sram_wl] <= sram_bl;
      sram_wr[sram_wl]  <= 1'b1;
    end else if (&sram_bl) begin
      rd_q <= sram_wr[sram_wl] ? sram_mem[sram_wl] : seed(sram_wl);
    end
  end
  assign sram_data_ready = dr_q & ~stuck;
  assign sram_op_type    = op_q;
  assign sram_rdata      = rd_q;

  logic [DW-1:0] ref_mem [256];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_op(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                       input bit stk, input bit flp, input int hold);
    int t0, tr, th, n, rel;
    bit ok;
    logic          exp_err;
    logic [DW-1:0] exp_rd;
    logic [DW-1:0] exp_bl;
    stuck = stk;
    flip  = flp;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    chk("req_ready_wait", 64'(req_ready), 64'd1);
    exp_err = stk | flp;
    exp_rd  = (wr || exp_err) ? '0 : ref_mem[addr];
    exp_bl  = wr ? wd : '1;
    if (wr) ref_mem[addr] = wd;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    t0 = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = AW'($urandom);
    req_wdata = {$urandom, $urandom};
    req_write = 1'($urandom);
    chk("drive_wl", 64'(sram_wl), 64'(addr));
    chk("drive_rw_sel", 64'(sram_rw_sel), 64'(wr));
    chk("drive_bl", sram_bl, exp_bl);
    ok = 1'b1; n = 0;
    while (!rsp_valid && n < 40) begin
      if (sram_wl !== addr || sram_rw_sel !== wr || sram_bl !== exp_bl) ok = 1'b0;
      @(negedge clk); n++;
    end
    chk("access_stable", 64'(ok), 64'd1);
    chk("rsp_latency", 64'(cyc - t0), stk ? 64'(TO + 1) : 64'd4);
    chk("rsp_err", 64'(rsp_err), 64'(exp_err));
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_write", 64'(rsp_write), 64'(wr));
    chk("resp_idle_drive", {sram_bl[DW-1:10], sram_wl, sram_rw_sel, sram_bl[0]}, 64'd0);
    tr = cyc;
    ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_err !== exp_err || rsp_rdata !== exp_rd ||
          rsp_write !== wr || req_ready !== 1'b0) ok = 1'b0;
    end
    chk("rsp_hold_stable", 64'(ok), 64'd1);
    rsp_ready = 1'b1;
    th = cyc;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_drop", 64'(rsp_valid), 64'd0);
    n = 0;
    while (!req_ready && n < 40) begin @(negedge clk); n++; end
    rel = stk ? th + 1 : ((th + 1 > tr + 2) ? th + 1 : tr + 2);
    chk("req_ready_return", 64'(cyc), 64'(rel + 1));
    stuck = 1'b0;
    flip  = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic [DW-1:0] rw;
    for (int i = 0; i < 256; i++) ref_mem[i] = seed(AW'(i));
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {req_ready, rsp_valid, rsp_write, rsp_err, sram_rw_sel, sram_wl, rsp_rdata[50:0]},
        64'd0);
    chk("reset_bl", sram_bl, 64'd0);
    chk("reset_rdata", rsp_rdata, 64'd0);
    rst = 1'b0;

    do_op(1'b0, 8'h2A, '0, 1'b0, 1'b0, 0);
    do_op(1'b1, 8'h05, 64'h01234567_89ABCDEF, 1'b0, 1'b0, 0);
    do_op(1'b0, 8'h05, '0, 1'b0, 1'b0, 0);
    do_op(1'b0, 8'h11, '0, 1'b1, 1'b0, 0);
    do_op(1'b0, 8'h2A, '0, 1'b0, 1'b1, 0);
    do_op(1'b1, 8'h07, 64'hFFFF_0000_1234_5678, 1'b0, 1'b1, 1);
    do_op(1'b0, 8'h2A, '0, 1'b0, 1'b0, 10);

    // Reset in the middle of a write; the SRAM still sees the first drive.
    while (!req_ready) @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h33; req_wdata = 64'hCAFE_F00D_0000_0001;
    ref_mem[8'h33] = 64'hCAFE_F00D_0000_0001;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_rw_sel", 64'(sram_rw_sel), 64'd0);
    chk("midrst_bl", sram_bl, 64'd0);
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_req_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    do_op(1'b0, 8'h33, '0, 1'b0, 1'b0, 0);

    for (int k = 0; k < 40; k++) begin
      ra = AW'($urandom_range(0, 15));
      rw = {$urandom, $urandom};
      do_op(1'($urandom), ra, rw, $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
            int'($urandom_range(0, 3)));
    end

    chk("no_ready_during_rsp", 64'(overlap), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
